// File: rtl/ids_dma_if.sv
// ids_dma_if -- bus-side signal bundle of the IDS DMA engine.
//   o_req_dma / i_gnt_dma        : bus request and grant
//   o_dma_*_0 / i_dma_dout_0     : channel 0, used for reads from the PIM buffer
//   o_dma_*_1 / i_dma_dout_1     : channel 1, used for writes into PIM
// Modports: master = DMA engine side, slave = bus / memory side.
interface ids_dma_if;
    logic        o_req_dma;
    logic        i_gnt_dma;

    logic [31:0] o_dma_addr_0;
    logic        o_dma_write_0;
    logic        o_dma_read_0;
    logic [3:0]  o_dma_size_0;
    logic [31:0] o_dma_din_0;
    logic [31:0] i_dma_dout_0;

    logic [31:0] o_dma_addr_1;
    logic        o_dma_write_1;
    logic        o_dma_read_1;
    logic [3:0]  o_dma_size_1;
    logic [31:0] o_dma_din_1;
    logic [31:0] i_dma_dout_1;

    modport master (
        output o_req_dma,
        input  i_gnt_dma,
        output o_dma_addr_0, o_dma_write_0, o_dma_read_0, o_dma_size_0, o_dma_din_0,
        input  i_dma_dout_0,
        output o_dma_addr_1, o_dma_write_1, o_dma_read_1, o_dma_size_1, o_dma_din_1,
        input  i_dma_dout_1
    );

    modport slave (
        input  o_req_dma,
        output i_gnt_dma,
        input  o_dma_addr_0, o_dma_write_0, o_dma_read_0, o_dma_size_0, o_dma_din_0,
        output i_dma_dout_0,
        input  o_dma_addr_1, o_dma_write_1, o_dma_read_1, o_dma_size_1, o_dma_din_1,
        output i_dma_dout_1
    );
endinterface

// File: rtl/ids_dma.sv
// ids_dma -- word-by-word copy engine from a PIM buffer (channel 0 reads)
// into PIM (channel 1 writes), one word per RD -> CAP -> WR round trip.
// Ports:
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_start              : one-cycle start pulse, honoured only while idle
//   i_src_addr/i_dst_addr: byte addresses, advanced by 4 per word (mod 2^32)
//   i_len                : number of 32-bit words (0 = immediate done)
//   o_busy, o_done, o_err: status; o_done is a one-cycle pulse
//   bus                  : ids_dma_if.master, request/grant plus both channels
// Optional feature: define DMA_ADDR_CHECK_EN to reject starts whose source is
// not in region 0x2xxx_xxxx or whose destination is not in 0x4xxx_xxxx; the
// rejection is reported on the sticky o_err. Without it o_err is tied 0.
// All outputs come straight from flops, so reset clears them immediately.
module ids_dma (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_src_addr,
    input  logic [31:0] i_dst_addr,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    ids_dma_if.master   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_r, state_next_s;
    logic [31:0] src_r, src_next_s;
    logic [31:0] dst_r, dst_next_s;
    logic [15:0] rem_r, rem_next_s;
    logic [31:0] data_r, data_next_s;

    logic        busy_r, busy_next_s;
    logic        done_r, done_next_s;
    logic        req_r, req_next_s;
    logic        rd0_r, rd0_next_s;
    logic [31:0] addr0_r, addr0_next_s;
    logic        wr1_r, wr1_next_s;
    logic [31:0] addr1_r, addr1_next_s;
    logic [31:0] din1_r, din1_next_s;

    logic        cfg_ok_s;
    logic        unused_s;

`ifdef DMA_ADDR_CHECK_EN
    logic        err_r;

    assign cfg_ok_s = (i_src_addr[31:28] == 4'h2) && (i_dst_addr[31:28] == 4'h4);

    // Sticky error: every start taken in IDLE either sets or clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_r <= 1'b0;
        end else if ((state_r == IDLE) && i_start) begin
            err_r <= !cfg_ok_s;
        end
    end

    assign o_err = err_r;
`else
    assign cfg_ok_s = 1'b1;
    assign o_err    = 1'b0;
`endif

    // Next-state and datapath update; a beat advances only on req & gnt.
    always_comb begin
        state_next_s = state_r;
        src_next_s   = src_r;
        dst_next_s   = dst_r;
        rem_next_s   = rem_r;
        data_next_s  = data_r;
        case (state_r)
            IDLE: begin
                if (i_start && cfg_ok_s) begin
                    src_next_s   = i_src_addr;
                    dst_next_s   = i_dst_addr;
                    rem_next_s   = i_len;
                    state_next_s = (i_len == 16'd0) ? DONE : RD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD: begin
                if (req_r && bus.i_gnt_dma) begin
                    state_next_s = CAP;
                end else begin
                    state_next_s = RD;
                end
            end
            CAP: begin
                // Read data is valid exactly one cycle after the accepted read.
                data_next_s  = bus.i_dma_dout_0;
                state_next_s = WR;
            end
            WR: begin
                if (req_r && bus.i_gnt_dma) begin
                    src_next_s   = src_r + 32'd4;
                    dst_next_s   = dst_r + 32'd4;
                    rem_next_s   = rem_r - 16'd1;
                    state_next_s = (rem_r == 16'd1) ? DONE : RD;
                end else begin
                    state_next_s = WR;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        busy_next_s  = (state_next_s != IDLE);
        done_next_s  = (state_next_s == DONE);
        rd0_next_s   = (state_next_s == RD);
        wr1_next_s   = (state_next_s == WR);
        req_next_s   = rd0_next_s || wr1_next_s;
        addr0_next_s = rd0_next_s ? src_next_s  : 32'd0;
        addr1_next_s = wr1_next_s ? dst_next_s  : 32'd0;
        din1_next_s  = wr1_next_s ? data_next_s : 32'd0;
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            src_r   <= 32'd0;
            dst_r   <= 32'd0;
            rem_r   <= 16'd0;
            data_r  <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            req_r   <= 1'b0;
            rd0_r   <= 1'b0;
            addr0_r <= 32'd0;
            wr1_r   <= 1'b0;
            addr1_r <= 32'd0;
            din1_r  <= 32'd0;
        end else begin
            state_r <= state_next_s;
            src_r   <= src_next_s;
            dst_r   <= dst_next_s;
            rem_r   <= rem_next_s;
            data_r  <= data_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
            req_r   <= req_next_s;
            rd0_r   <= rd0_next_s;
            addr0_r <= addr0_next_s;
            wr1_r   <= wr1_next_s;
            addr1_r <= addr1_next_s;
            din1_r  <= din1_next_s;
        end
    end

    assign o_busy            = busy_r;
    assign o_done            = done_r;
    assign bus.o_req_dma     = req_r;

    assign bus.o_dma_addr_0  = addr0_r;
    assign bus.o_dma_read_0  = rd0_r;
    assign bus.o_dma_write_0 = 1'b0;
    assign bus.o_dma_size_0  = rd0_r ? 4'b1111 : 4'b0000;
    assign bus.o_dma_din_0   = 32'd0;

    assign bus.o_dma_addr_1  = addr1_r;
    assign bus.o_dma_write_1 = wr1_r;
    assign bus.o_dma_read_1  = 1'b0;
    assign bus.o_dma_size_1  = wr1_r ? 4'b1111 : 4'b0000;
    assign bus.o_dma_din_1   = din1_r;

    // Channel 1 never reads, so its read-data input has no consumer.
    assign unused_s = ^bus.i_dma_dout_1;
endmodule

// File: tb/tb_ids_dma.sv
// tb_ids_dma -- self-checking bench for ids_dma. A memory responder returns
// a hashed word per read address; expected writes, latency and busy time are
// derived from the transfer parameters alone.
module tb_ids_dma;
    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [31:0] i_src_addr;
    logic [31:0] i_dst_addr;
    logic [15:0] i_len;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    ids_dma_if bus ();

    ids_dma dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_src_addr (i_src_addr),
        .i_dst_addr (i_dst_addr),
        .i_len      (i_len),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .bus        (bus)
    );

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    // Monitor state (written only by the monitor process)
    logic [63:0] wr_log[$];
    int          rd_total   = 0;
    int          done_total = 0;
    int          busy_total = 0;
    int          req_total  = 0;
    int          viol       = 0;
    int          last_done_cyc = 0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_pend_addr = 32'd0;
    logic        prev_rd_wait = 1'b0;
    logic        prev_wr_wait = 1'b0;
    logic [31:0] prev_addr0 = 32'd0;
    logic [31:0] prev_addr1 = 32'd0;
    logic [31:0] prev_din1  = 32'd0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read-data responder: valid only in the cycle after an accepted read.
    always @(posedge i_clk) begin
        #1;
        bus.i_dma_dout_0 = rd_pend ? mem_word(rd_pend_addr) : $urandom();
    end

    // Bus monitor, sampled mid-cycle.
    always @(negedge i_clk) begin : mon
        logic rd_acc;
        logic wr_acc;
        int   v;
        rd_acc = bus.o_req_dma && bus.o_dma_read_0 && bus.i_gnt_dma;
        wr_acc = bus.o_req_dma && bus.o_dma_write_1 && bus.i_gnt_dma;
        v = 0;
        if (bus.o_dma_write_0 !== 1'b0 || bus.o_dma_din_0 !== 32'd0 || bus.o_dma_read_1 !== 1'b0) v++;
        if (bus.o_dma_size_0 !== (bus.o_dma_read_0 ? 4'hF : 4'h0)) v++;
        if (bus.o_dma_size_1 !== (bus.o_dma_write_1 ? 4'hF : 4'h0)) v++;
        if (!bus.o_dma_read_0 && bus.o_dma_addr_0 !== 32'd0) v++;
        if (!bus.o_dma_write_1 && (bus.o_dma_addr_1 !== 32'd0 || bus.o_dma_din_1 !== 32'd0)) v++;
        if ((bus.o_dma_read_0 || bus.o_dma_write_1) && !bus.o_req_dma) v++;
        if (o_done && !o_busy) v++;
        if (prev_rd_wait && !(bus.o_dma_read_0 && bus.o_dma_addr_0 == prev_addr0)) v++;
        if (prev_wr_wait && !(bus.o_dma_write_1 && bus.o_dma_addr_1 == prev_addr1
                              && bus.o_dma_din_1 == prev_din1)) v++;
        viol <= viol + v;
        if (rd_acc) rd_total <= rd_total + 1;
        if (wr_acc) wr_log.push_back({bus.o_dma_addr_1, bus.o_dma_din_1});
        if (o_done) begin
            done_total    <= done_total + 1;
            last_done_cyc <= cyc;
        end
        if (o_busy) busy_total <= busy_total + 1;
        if (bus.o_req_dma) req_total <= req_total + 1;
        rd_pend      <= rd_acc;
        rd_pend_addr <= bus.o_dma_addr_0;
        prev_rd_wait <= bus.o_dma_read_0 && !bus.i_gnt_dma;
        prev_wr_wait <= bus.o_dma_write_1 && !bus.i_gnt_dma;
        prev_addr0   <= bus.o_dma_addr_0;
        prev_addr1   <= bus.o_dma_addr_1;
        prev_din1    <= bus.o_dma_din_1;
    end

    function automatic logic all_outs_zero();
        all_outs_zero = ({o_busy, o_done, o_err, bus.o_req_dma,
                          bus.o_dma_addr_0, bus.o_dma_write_0, bus.o_dma_read_0,
                          bus.o_dma_size_0, bus.o_dma_din_0,
                          bus.o_dma_addr_1, bus.o_dma_write_1, bus.o_dma_read_1,
                          bus.o_dma_size_1, bus.o_dma_din_1} == 144'd0);
    endfunction

    // One transfer: optional random grant, a grant stall window [st_at, st_at+st_len)
    // in cycles after start, and an optional start pulse injected at cycle inj_at.
    task automatic xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                        input bit rnd, input int st_at, input int st_len, input int inj_at);
        int base_wr   = wr_log.size();
        int base_rd   = rd_total;
        int base_done = done_total;
        int base_busy = busy_total;
        int base_viol = viol;
        int scyc;
        int lat;
        int budget    = 40 * int'(n) + 40;
        int i         = 0;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_src_addr = s; i_dst_addr = d; i_len = n; bus.i_gnt_dma = 1'b1;
        scyc = cyc;
        while (done_total == base_done && i < budget) begin
            @(posedge i_clk); #1;
            i++;
            if (i == inj_at) begin
                i_start = 1'b1; i_src_addr = s ^ 32'h0000_0100; i_dst_addr = d ^ 32'h0000_0200;
                i_len = n + 16'd3;
            end else begin
                i_start = 1'b0; i_src_addr = s; i_dst_addr = d; i_len = n;
            end
            bus.i_gnt_dma = (i >= st_at && i < st_at + st_len) ? 1'b0
                          : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        i_start = 1'b0;
        bus.i_gnt_dma = 1'b1;
        check("done_pulse", 64'(done_total - base_done), 64'd1);
        lat = last_done_cyc - scyc;
        if (!rnd) check("latency", 64'(lat), 64'(3 * int'(n) + 1 + st_len));
        check("busy_cycles", 64'(busy_total - base_busy), 64'(lat));
        check("write_count", 64'(wr_log.size() - base_wr), 64'(n));
        check("read_count", 64'(rd_total - base_rd), 64'(n));
        for (int k = 0; k < int'(n) && base_wr + k < wr_log.size(); k++) begin
            check("write_beat", wr_log[base_wr + k],
                  {d + 32'(4 * k), mem_word(s + 32'(4 * k))});
        end
        check("bus_rules", 64'(viol - base_viol), 64'd0);
        repeat (3) @(posedge i_clk);
        #1;
        check("idle_after", {63'd0, o_busy}, 64'd0);
        check("no_restart", 64'(done_total - base_done), 64'd1);
        check("err_clear", {63'd0, o_err}, 64'd0);
    endtask

    initial begin
        int base_req;
        int base_done;
        i_rst_n = 1'b0; i_start = 1'b0; i_src_addr = 32'd0; i_dst_addr = 32'd0; i_len = 16'd0;
        bus.i_gnt_dma = 1'b0;
        bus.i_dma_dout_1 = $urandom();

        // Reset state
        repeat (3) @(negedge i_clk);
        check("reset_outs", {63'd0, all_outs_zero()}, 64'd1);
        i_rst_n = 1'b1;
        bus.i_gnt_dma = 1'b1;
        @(posedge i_clk); #1;
        check("idle_busy", {63'd0, o_busy}, 64'd0);

        // Basic copy, 3 words, continuous grant
        xfer(32'h2000_0000, 32'h4000_0010, 16'd3, 1'b0, 0, 0, -1);
        // Grant withheld for 4 cycles during the first read
        xfer(32'h2000_0100, 32'h4000_0200, 16'd2, 1'b0, 1, 4, -1);
        // Zero-length start
        xfer(32'h2000_0300, 32'h4000_0400, 16'd0, 1'b0, 0, 0, -1);
        // Start pulse during CAP of the first word is ignored
        xfer(32'h2000_0500, 32'h4000_0600, 16'd4, 1'b0, 0, 0, 2);

        // Reset during WR of word 2 of 5
        @(posedge i_clk); #1;
        i_start = 1'b1; i_src_addr = 32'h2000_0700; i_dst_addr = 32'h4000_0800; i_len = 16'd5;
        for (int i = 1; i <= 6; i++) begin
            @(posedge i_clk); #1;
            i_start = 1'b0;
        end
        check("pre_reset_wr", {63'd0, bus.o_dma_write_1}, 64'd1);
        #2 i_rst_n = 1'b0;
        #1 check("midreset_outs", {63'd0, all_outs_zero()}, 64'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        base_req = req_total;
        repeat (3) @(posedge i_clk);
        #1;
        check("post_reset_idle", {63'd0, o_busy}, 64'd0);
        check("post_reset_noreq", 64'(req_total - base_req), 64'd0);
        xfer(32'h2000_0900, 32'h4000_0A00, 16'd1, 1'b0, 0, 0, -1);

`ifdef DMA_ADDR_CHECK_EN
        // Source outside the PIM-buffer region is rejected
        base_req  = req_total;
        base_done = done_total;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_src_addr = 32'h4000_0000; i_dst_addr = 32'h4000_0000; i_len = 16'd2;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (6) @(posedge i_clk);
        #1;
        check("addr_err_set", {63'd0, o_err}, 64'd1);
        check("addr_err_noreq", 64'(req_total - base_req), 64'd0);
        check("addr_err_nodone", 64'(done_total - base_done), 64'd0);
        check("addr_err_idle", {63'd0, o_busy}, 64'd0);
        xfer(32'h2000_0B00, 32'h4000_0C00, 16'd2, 1'b0, 0, 0, -1);
`else
        // 32-bit address wrap
        base_done = done_total;
        xfer(32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd3, 1'b0, 0, 0, -1);
`endif

        // Randomized transfers
        for (int t = 0; t < 20; t++) begin
            logic [31:0] rs;
            logic [31:0] rd;
            logic [15:0] rl;
            rs = {4'h2, 28'($urandom())};
            rd = {4'h4, 28'($urandom())};
            rl = 16'($urandom_range(1, 8));
            xfer(rs, rd, rl, (t % 4) != 0, 0, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
